// File: rtl/viterbi_pkg.sv
// Constants shared by the convolutional encoder and the Viterbi decoder:
// code geometry, default generator polynomials and encoder FSM encoding.
package viterbi_pkg;

    localparam int K        = 9;
    localparam int WD_CODE  = 2;
    localparam int SR_W     = K - 1;
    localparam int TAIL_LEN = K - 1;

    localparam logic [K-1:0] G0_DEFAULT = 9'o561;
    localparam logic [K-1:0] G1_DEFAULT = 9'o753;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } enc_state_e;

endpackage

// File: rtl/conv_symbol.sv
// Combinational rate-1/2 symbol generator: one input bit plus the K-1 bit
// history yields {c1, c0}. Also used by the decoder's branch-metric unit.
module conv_symbol #(
    parameter int K = 9
) (
    input  logic         x_i,
    input  logic [K-2:0] sr_i,
    input  logic [K-1:0] g0_i,
    input  logic [K-1:0] g1_i,
    output logic [1:0]   sym_o
);

    logic [K-1:0] win;

    // Newest bit sits at the window MSB, oldest history bit at the LSB.
    always_comb begin
        win      = '0;
        win[K-1] = x_i;
        for (int i = 0; i < K-1; i++) begin
            win[K-2-i] = sr_i[i];
        end
    end

    assign sym_o = {^(win & g1_i), ^(win & g0_i)};

endmodule

// File: rtl/conv_frame_encoder.sv
// Framed K=9 rate-1/2 convolutional encoder with valid/ready on both sides;
// every frame is closed with K-1 zero tail symbols so the trellis ends in state 0.
module conv_frame_encoder #(
    parameter int            K     = viterbi_pkg::K,
    parameter logic [K-1:0]  G0    = viterbi_pkg::G0_DEFAULT,
    parameter logic [K-1:0]  G1    = viterbi_pkg::G1_DEFAULT,
    parameter int            CNT_W = 16
) (
    input  logic                             CLOCK,
    input  logic                             Reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_bit,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [viterbi_pkg::WD_CODE-1:0]  Code,
    output logic                             out_last,
    output logic [CNT_W-1:0]                 frame_cnt
);

    import viterbi_pkg::*;

    localparam int              TC_W      = $clog2(K);
    localparam logic [TC_W-1:0] TAIL_INIT = TC_W'(K - 1);

    enc_state_e          state_q, state_d;
    logic [K-2:0]        sr_q, sr_d;
    logic [TC_W-1:0]     tail_cnt_q, tail_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [WD_CODE-1:0]  code_q, code_d;
    logic                out_last_q, out_last_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic                slot_free;
    logic                accept;
    logic                tail_emit;
    logic                sym_x;
    logic [WD_CODE-1:0]  sym;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = Reset && (state_q != ST_TAIL) && slot_free;
    assign accept    = in_valid && in_ready;
    assign tail_emit = (state_q == ST_TAIL) && slot_free;
    // Tail symbols shift in zeros; data symbols shift in the accepted bit.
    assign sym_x     = accept && in_bit;

    conv_symbol #(
        .K (K)
    ) u_sym (
        .x_i   (sym_x),
        .sr_i  (sr_q),
        .g0_i  (G0),
        .g1_i  (G1),
        .sym_o (sym)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        code_d      = code_q;
        out_last_d  = out_last_q;
        frame_cnt_d = frame_cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            out_valid_d = 1'b1;
            code_d      = sym;
            out_last_d  = 1'b0;
            sr_d        = {sr_q[K-3:0], sym_x};
            if (in_last) begin
                state_d    = ST_TAIL;
                tail_cnt_d = TAIL_INIT;
            end else begin
                state_d    = ST_DATA;
            end
        end else if (tail_emit) begin
            out_valid_d = 1'b1;
            code_d      = sym;
            sr_d        = {sr_q[K-3:0], 1'b0};
            tail_cnt_d  = tail_cnt_q - TC_W'(1);
            out_last_d  = (tail_cnt_q == TC_W'(1));
            if (tail_cnt_q == TC_W'(1)) begin
                state_d     = ST_IDLE;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset discards any partial frame outright; no tail is flushed.
    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Code      = code_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;

    a_last_has_valid : assert property (@(posedge CLOCK) disable iff (!Reset)
        out_last_q |-> out_valid_q);
    a_tail_blocks_input : assert property (@(posedge CLOCK) disable iff (!Reset)
        (state_q == ST_TAIL) |-> !in_ready);

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Table-driven bench for conv_frame_encoder: frames, backpressure patterns and
// expected symbol streams are listed per vector, plus reset-related sequences.
module tb_conv_frame_encoder;

    logic        clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  Code;
    logic        out_last;
    logic [15:0] frame_cnt;

    conv_frame_encoder dut (
        .CLOCK     (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Code      (Code),
        .out_last  (out_last),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          nbits;
        logic [15:0] bits;    // sent MSB-first: bits[nbits-1] goes first
        int          reps;    // frames offered back-to-back
        int          rmode;   // 0: out_ready=1, 1: 1,0,0,..., 2: 1,0,1,0,...
        int          nexp;    // symbols per frame
        logic [47:0] exp;     // symbol i at exp[2i+1:2i]
    } vec_t;

    vec_t vt[6];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   exp_frames = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic set_vec(input int i, input int nbits, input logic [15:0] bits,
                           input int reps, input int rmode, input int nexp,
                           input logic [47:0] expv);
        vt[i].nbits = nbits;
        vt[i].bits  = bits;
        vt[i].reps  = reps;
        vt[i].rmode = rmode;
        vt[i].nexp  = nexp;
        vt[i].exp   = expv;
    endtask

    // Direct convolution sum over the generator taps (tap j delays the input by j).
    function automatic logic [47:0] ref_encode(input logic [15:0] bits, input int n);
        logic [8:0]  g0 = 9'o561;
        logic [8:0]  g1 = 9'o753;
        logic [23:0] u;
        logic [47:0] r;
        logic        c0, c1;
        u = '0;
        r = '0;
        for (int i = 0; i < n; i++) u[i] = bits[n-1-i];
        for (int t = 0; t < n + 8; t++) begin
            c0 = 1'b0;
            c1 = 1'b0;
            for (int j = 0; j < 9; j++) begin
                if (t - j >= 0) begin
                    c0 = c0 ^ (g0[8-j] & u[t-j]);
                    c1 = c1 ^ (g1[8-j] & u[t-j]);
                end
            end
            r[2*t +: 2] = {c1, c0};
        end
        return r;
    endfunction

    task automatic run_vector(input int v);
        int          idx, fidx, nsym, nlast, cyc, stall_err, tail_err, k;
        logic        in_tail, prev_stall, prev_last;
        logic [1:0]  prev_code;
        logic [1:0]  rc[64];
        logic        rl[64];
        idx = 0; fidx = 0; nsym = 0; nlast = 0; cyc = 0;
        stall_err = 0; tail_err = 0;
        in_tail = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_code = 2'd0;
        while (nlast < vt[v].reps && cyc < 1000) begin
            @(negedge clk);
            case (vt[v].rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 3) == 0);
                default: out_ready = ((cyc % 2) == 0);
            endcase
            in_valid = (fidx < vt[v].reps);
            in_bit   = in_valid ? vt[v].bits[vt[v].nbits-1-idx] : 1'b0;
            in_last  = in_valid && (idx == vt[v].nbits - 1);
            #1;
            if (prev_stall && !(out_valid && Code === prev_code && out_last === prev_last))
                stall_err++;
            if (in_tail && !(out_valid && out_last) && in_ready)
                tail_err++;
            if (out_valid && out_last) in_tail = 1'b0;
            if (out_valid && out_ready) begin
                if (nsym < 64) begin
                    rc[nsym] = Code;
                    rl[nsym] = out_last;
                end
                nsym++;
                if (out_last) nlast++;
            end
            if (in_valid && in_ready) begin
                if (in_last) begin
                    in_tail = 1'b1;
                    fidx++;
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_code  = Code;
            prev_last  = out_last;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        exp_frames += vt[v].reps;
        chk($sformatf("v%0d frames_done", v), nlast, vt[v].reps);
        chk($sformatf("v%0d symbol_count", v), nsym, vt[v].nexp * vt[v].reps);
        for (int i = 0; i < nsym && i < 64 && i < vt[v].nexp * vt[v].reps; i++) begin
            k = i % vt[v].nexp;
            chk($sformatf("v%0d code[%0d]", v, i), rc[i], vt[v].exp[2*k +: 2]);
            chk($sformatf("v%0d last[%0d]", v, i), rl[i], (k == vt[v].nexp - 1));
        end
        chk($sformatf("v%0d stall_stable", v), stall_err, 0);
        chk($sformatf("v%0d tail_in_ready", v), tail_err, 0);
        chk($sformatf("v%0d frame_cnt", v), frame_cnt, exp_frames);
        chk($sformatf("v%0d drained", v), out_valid, 0);
    endtask

    initial begin
        int          imp[9] = '{3, 2, 3, 3, 1, 2, 0, 2, 3};
        int          two[10] = '{3, 1, 1, 0, 2, 3, 2, 2, 1, 3};
        logic [47:0] imp_p, two_p;
        int          nsym, cyc, idx;

        imp_p = '0;
        two_p = '0;
        for (int i = 0; i < 9; i++)  imp_p[2*i +: 2] = 2'(imp[i]);
        for (int i = 0; i < 10; i++) two_p[2*i +: 2] = 2'(two[i]);

        set_vec(0, 1,  16'h0001, 1, 0, 9,  imp_p);
        set_vec(1, 4,  16'h0000, 1, 0, 12, 48'd0);
        set_vec(2, 16, 16'b1010101001110101, 1, 0, 24,
                ref_encode(16'b1010101001110101, 16));
        set_vec(3, 1,  16'h0001, 1, 1, 9,  imp_p);
        set_vec(4, 1,  16'h0001, 2, 0, 9,  imp_p);
        set_vec(5, 2,  16'h0003, 1, 2, 10, two_p);

        Reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst Code", Code, 0);
        chk("rst out_last", out_last, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        chk("rst in_ready", in_ready, 0);
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst in_ready", in_ready, 1);

        for (int v = 0; v < 6; v++) run_vector(v);

        // Reset mid-frame after the third data symbol has been consumed.
        nsym = 0; cyc = 0; idx = 0;
        while (nsym < 3 && cyc < 50) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_bit    = (idx != 1);
            in_last   = 1'b0;
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) nsym++;
            @(posedge clk);
            cyc++;
        end
        chk("midrst symbols_seen", nsym, 3);
        @(negedge clk);
        Reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        #1;
        chk("midrst in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst Code", Code, 0);
        chk("midrst out_last", out_last, 0);
        chk("midrst frame_cnt", frame_cnt, 0);
        @(negedge clk);
        Reset = 1'b1;
        exp_frames = 0;
        run_vector(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/conv_frame_encoder.md
# conv_frame_encoder

Frame-oriented rate-1/2, K=9 convolutional encoder with valid/ready handshakes on both sides and automatic zero-tail termination. It is the transmit-side counterpart of the Viterbi decoder: it turns a framed bit stream into `WD_CODE`-bit code symbols that feed the decoder's `Code` input. Because every frame returns the trellis to state 0, the decoder's traceback always starts from a known state.

## Interface
- `K`, 9: constraint length; the shift register holds K-1 = 8 bits.
- `G0`, 9'o561: generator polynomial for code bit 0.
- `G1`, 9'o753: generator polynomial for code bit 1.
- `CNT_W`, 16: width of the completed-frame counter.

- `CLOCK`  in  1  rising-edge clock.
- `Reset`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `in_bit` is offered.
- `in_ready`  out  1  encoder accepts `in_bit` this cycle.
- `in_bit`  in  1  information bit.
- `in_last`  in  1  marks the final information bit of the frame.
- `out_valid`  out  1  `Code` holds a symbol.
- `out_ready`  in  1  downstream consumes the symbol.
- `Code`  out  2  symbol: `Code[0]`=c0, `Code[1]`=c1.
- `out_last`  out  1  marks the final tail symbol of the frame.
- `frame_cnt`  out  CNT_W  number of completed frames; wraps modulo 2^CNT_W.

## Operation
- **State register** `sr[7:0]`: `sr[0]` is the most recent past input. On each emitted symbol, `sr <= {sr[6:0], x}`.
- **Encoding window** `w[8:0]`: `w[8]=x`, `w[7]=sr[0]`, …, `w[0]=sr[7]`.
  - `c0 = ^(w & G0)`
  - `c1 = ^(w & G1)`
- **FSM states: IDLE, DATA, TAIL.**
  - IDLE: `sr` is all zero.
    - Accepted bit with `in_last`=0: go to DATA.
    - Accepted bit with `in_last`=1: go to TAIL.
  - DATA: emit one symbol per accepted bit. An accepted bit with `in_last`=1 goes to TAIL and loads `tail_cnt`=8.
  - TAIL:
    - `in_ready`=0.
    - Whenever the output slot is free, emit a symbol with x=0 and decrement `tail_cnt`.
    - The symbol emitted with `tail_cnt`=1 carries `out_last`=1. On that symbol: go to IDLE and increment `frame_cnt`. `sr` is zero at this point by construction.
- **Output slot** is a single register.
  - It is free when `!out_valid || out_ready`.
  - `in_ready` = (state != TAIL) && slot free.
  - Throughput is one symbol per cycle under continuous `out_ready`.
- **Frame length:** a frame of N information bits yields exactly N+8 symbols. Only the last of them has `out_last`=1.
- **Inputs outside DATA/IDLE:** `in_valid` during TAIL is not accepted. The upstream holds the bit, per normal ready semantics. `in_last` is sampled only on an accepted beat.
- **Reset** (`Reset`=0 at a rising edge), from any state including mid-frame or mid-tail:
  - state→IDLE, `sr`→0, `tail_cnt`→0
  - `out_valid`→0, `Code`→0, `out_last`→0, `frame_cnt`→0
  - Any partial frame is discarded; no tail is emitted.
- **Output reset values:** `in_ready` is 0 while `Reset`=0 and 1 in the first cycle after release (IDLE, slot empty). All other outputs are 0.

## Timing
- **Latency:** an accepted bit at edge t produces `out_valid`/`Code` valid after edge t, i.e. 1 cycle.
- **Tail start:** the first tail symbol appears on the edge after the `in_last` symbol is consumed. With `out_ready`=1 it follows back-to-back, with no bubble.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `Code` and `out_last` stay stable and the FSM, `sr` and `tail_cnt` hold.
- **Simultaneous consume + new accept:** the slot reloads in the same cycle (consume and refill at one edge).
- **Next frame:** the first `in_ready` of frame k+1 is asserted in the cycle after the `out_last` symbol is loaded, provided the slot is free.
- **`frame_cnt`** updates on the edge that loads the `out_last` symbol.

## Structure
- **Package `viterbi_pkg`:** `K`, `WD_CODE`=2, the default `G0`/`G1`, the tail length K-1, and the FSM state encoding (IDLE, DATA, TAIL). The Viterbi decoder reuses the same constants.
- **Sub-module `conv_symbol`:** combinational; inputs x, `sr`, `G0`, `G1`; output the 2-bit symbol. It is shared with the decoder's branch-metric generation.

## Test plan
- **Impulse:** single bit 1 with `in_last`=1, `out_ready`=1 → `Code` sequence 3,2,3,3,1,2,0,2,3; `out_last` on the 9th symbol only; `frame_cnt`=1.
- **All-zero frame:** 4 bits of 0 → 12 symbols, all 0; `out_last` on the 12th; `sr`=0 afterward.
- **Backpressure:** impulse frame with `out_ready` toggling 1,0,0,1,… → identical symbol sequence; `Code` stable while stalled; no dropped or duplicated symbols; `in_ready`=0 throughout TAIL.
- **Back-to-back frames:** two impulse frames offered continuously → 18 symbols (two copies of 3,2,3,3,1,2,0,2,3); `frame_cnt`=2.
- **Reset mid-frame:** drive `Reset`=0 after the 3rd data symbol → all outputs are 0 on the next edge. A following impulse frame still yields exactly 3,2,3,3,1,2,0,2,3.
- **Decoder loopback:** 16-bit pattern 1010101001110101 → feed to `VITERBIDECODER`; decoded bits match the pattern.
